dmem_lsu: RTL

- Load/store unit directly downstream of the core datapath.
- Consumes the datapath's ALU address and store data plus decoded access controls; drives a word-wide valid/ready data-memory bus.
- Returns sign/zero-extended load data into the result mux and stalls the core while a bus transaction is outstanding.
- Performs byte-lane steering, misalignment detection and an optional bus timeout.

---
 rtl/dmem_lsu.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the core datapath and a word-wide
// valid/ready data-memory bus. Handles byte-lane steering, misalignment
// faults and sign/zero extension of load data.
// Optional bus timeout is compiled in with `define DMEM_LSU_TIMEOUT_EN.
module dmem_lsu #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_wstrb_q, bus_wstrb_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                fault_q, fault_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [1:0]          off_q, off_d;

  logic                misaligned;
  logic                idle_ok;
  logic                accept;
  logic [3:0]          steer_strb;
  logic [31:0]         steer_wdata;
  logic [31:0]         rdata_shift;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_ext;

`ifdef DMEM_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  // The cycle after a timeout abort the core still holds its request; it is
  // ignored so stall drops and the fault can be taken instead of a retry.
  assign idle_ok = ~abort_q;
`else
  assign idle_ok = 1'b1;
`endif

  assign accept    = (state_q == ST_IDLE) && req_valid && !misaligned && idle_ok;
  assign stall     = accept || (state_q == ST_BUS);
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;

  // Alignment check and store lane steering from the live request.
  always_comb begin
    misaligned  = 1'b0;
    steer_strb  = 4'b0000;
    steer_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        steer_strb  = 4'b0001 << req_addr[1:0];
        steer_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned  = req_addr[0];
        steer_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
        steer_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned  = |req_addr[1:0];
        steer_strb  = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Lane select and extension of the returned read word.
  always_comb begin
    rdata_shift = bus_rdata >> {off_q, 3'b000};
    lane_b      = rdata_shift[7:0];
    lane_h      = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    off_d       = off_q;
`ifdef DMEM_LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && idle_ok) begin
          if (misaligned) begin
            fault_d     = 1'b1;
            load_data_d = '0;
          end else begin
            bus_valid_d = 1'b1;
            bus_we_d    = req_write;
            bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            bus_wstrb_d = req_write ? steer_strb : 4'b0000;
            bus_wdata_d = steer_wdata;
            size_d      = req_size;
            unsigned_d  = req_unsigned;
            off_d       = req_addr[1:0];
`ifdef DMEM_LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
            state_d     = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus_ready) begin
          if (!bus_we_q) load_data_d = load_ext;
          bus_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
`ifdef DMEM_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          if (!bus_we_q) load_data_d = 32'hDEAD_BEEF;
          bus_valid_d = 1'b0;
          fault_d     = 1'b1;
          abort_d     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      off_q       <= '0;
`ifdef DMEM_LSU_TIMEOUT_EN
      cnt_q       <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      off_q       <= off_d;
`ifdef DMEM_LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
`endif
    end
  end

endmodule
